apu_sequencer: RTL and testbench

//  Parametrised successor of the 4-channel APU playback core. Steps through note memory from start_addr
//  to end_addr (inclusive) at a fixed note rate, presenting NUM_CH tone codes per note. Adds start/stop

---
 rtl/apu_pkg.sv | 24 ++
 rtl/apu_note_timer.sv | 31 +++
 rtl/apu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_apu_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared definitions for the APU note sequencer: FSM state encoding,
// note-period divider calculation, silence code and channel slice helper.
package apu_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Tone code that keeps a channel quiet
    localparam int unsigned TONE_SILENT = 0;

    // Clock cycles per note; the sequencer needs at least 3 (FETCH, LATCH, one HOLD)
    function automatic logic [31:0] calc_div(input logic [31:0] clk_hz, input logic [31:0] rate_hz);
        return clk_hz / rate_hz;
    endfunction

    // Lowest bit of channel ch inside a packed tone word
    function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned tone_w);
        return ch * tone_w;
    endfunction

endpackage

// File: rtl/apu_note_timer.sv
// Note hold timer: loaded on clear, counts down while enabled and flags
// terminal count at zero. Loading DIV-3 makes FETCH + LATCH + HOLD span
// exactly DIV cycles.
module apu_note_timer #(
    parameter logic [31:0] DIV = 32'd4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [31:0] LOAD = DIV - 32'd3;

    logic [31:0] r_cnt;

    // Countdown register, reloaded at every new note
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= LOAD;
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 32'd1;
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/apu_sequencer.sv
// APU note sequencer: walks note memory from start_addr to end_addr at a
// fixed note rate and presents NUM_CH tone codes per note.
// Optional feature macro: CHANNEL_MUTE_EN adds a per-channel mute input.
module apu_sequencer
    import apu_pkg::*;
#(
    parameter logic [31:0] MAIN_CLK_SPEED = 32'd50_000_000,
    parameter logic [31:0] NOTE_RATE      = 32'd4,
    parameter int          ADDR_W         = 10,
    parameter int          NUM_CH         = 4,
    parameter int          TONE_W         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W-1:0]        end_addr,
`ifdef CHANNEL_MUTE_EN
    input  logic [NUM_CH-1:0]        mute,
`endif
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [NUM_CH*TONE_W-1:0] mem_data,
    output logic [NUM_CH*TONE_W-1:0] tones,
    output logic                     note_clk,
    output logic                     busy,
    output logic                     done
);

    localparam logic [31:0] DIV = calc_div(MAIN_CLK_SPEED, NOTE_RATE);
    localparam int          DW  = NUM_CH * TONE_W;

    logic [1:0]        r_state,    w_state_nxt;
    logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
    logic [ADDR_W-1:0] r_start,    w_start_nxt;
    logic [ADDR_W-1:0] r_end,      w_end_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_mem_rd,   w_mem_rd_nxt;
    logic [DW-1:0]     r_note,     w_note_nxt;
    logic              r_note_clk, w_note_clk_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;
    logic              w_tmr_clr, w_tmr_en, w_tmr_tc;

    apu_note_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tmr_tc)
    );

    // Next-state and next-output decode; stop overrides everything outside IDLE
    always_comb begin
        // NOTE: every value assigned here is defaulted first so no latch is inferred.
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_start_nxt    = r_start;
        w_end_nxt      = r_end;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_rd_nxt   = 1'b0;
        w_note_nxt     = r_note;
        w_note_clk_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_tmr_clr      = 1'b0;
        w_tmr_en       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_start_nxt    = start_addr;
                    w_end_nxt      = end_addr;
                    w_addr_nxt     = start_addr;
                    w_mem_addr_nxt = start_addr;
                    w_mem_rd_nxt   = 1'b1;
                    w_state_nxt    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_note_nxt     = mem_data;
                w_note_clk_nxt = 1'b1;
                w_tmr_clr      = 1'b1;
                w_state_nxt    = ST_HOLD;
            end
            ST_HOLD: begin
                w_tmr_en = 1'b1;
                if (w_tmr_tc) begin
                    if (r_addr != r_end) begin
                        w_addr_nxt     = r_addr + ADDR_W'(1);
                        w_mem_addr_nxt = r_addr + ADDR_W'(1);
                        w_mem_rd_nxt   = 1'b1;
                        w_state_nxt    = ST_FETCH;
                    end else if (loop) begin
                        w_addr_nxt     = r_start;
                        w_mem_addr_nxt = r_start;
                        w_mem_rd_nxt   = 1'b1;
                        w_state_nxt    = ST_FETCH;
                    end else begin
                        w_note_nxt  = {NUM_CH{TONE_W'(TONE_SILENT)}};
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (stop && r_state != ST_IDLE) begin
            w_state_nxt    = ST_IDLE;
            w_note_nxt     = {NUM_CH{TONE_W'(TONE_SILENT)}};
            w_mem_rd_nxt   = 1'b0;
            w_note_clk_nxt = 1'b0;
            w_done_nxt     = 1'b0;
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_start    <= '0;
            r_end      <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_note     <= '0;
            r_note_clk <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_start    <= w_start_nxt;
            r_end      <= w_end_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_note     <= w_note_nxt;
            r_note_clk <= w_note_clk_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

`ifdef CHANNEL_MUTE_EN
    logic [DW-1:0] r_tones, w_tones_nxt;

    // Silence muted channels of the upcoming note word
    always_comb begin
        w_tones_nxt = w_note_nxt;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mute[i])
                w_tones_nxt[ch_lo(i, TONE_W) +: TONE_W] = TONE_W'(TONE_SILENT);
        end
    end

    // Registered tone output so mute lands one cycle after it changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tones <= '0;
        else
            r_tones <= w_tones_nxt;
    end

    assign tones = r_tones;
`else
    assign tones = r_note;
`endif

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign note_clk = r_note_clk;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_apu_sequencer.sv
// Self-checking bench for apu_sequencer with DIV = 8/2 = 4 and a
// synchronous-read note memory whose word is derived from the address.
module tb_apu_sequencer;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [9:0]  end_addr = '0;
    logic [3:0]  mute = 4'b0000;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data = '0;
    logic [15:0] tones;
    logic        note_clk;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    apu_sequencer #(
        .MAIN_CLK_SPEED (32'd8),
        .NOTE_RATE      (32'd2),
        .ADDR_W         (10),
        .NUM_CH         (4),
        .TONE_W         (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
`ifdef CHANNEL_MUTE_EN
        .mute       (mute),
`endif
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .tones      (tones),
        .note_clk   (note_clk),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [9:0] a);
        return {a[3:0] ^ 4'hC, a[9:6], a[5:2], a[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] muted(input logic [15:0] w, input logic [3:0] m);
        logic [15:0] r;
        r = w;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[i*4 +: 4] = 4'h0;
        return r;
    endfunction

    // Synchronous-read note memory
    always @(posedge clk)
        if (mem_rd) mem_data <= pat(mem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one clock edge; returns in the FETCH cycle
    task automatic pulse_start(input logic [9:0] s, input logic [9:0] e, input logic l);
        @(negedge clk);
        start = 1'b1;
        start_addr = s;
        end_addr = e;
        loop = l;
        @(negedge clk);
        start = 1'b0;
        start_addr = $urandom_range(1023, 0);
        end_addr = $urandom_range(1023, 0);
    endtask

    // Play s..e: expected address list comes from the sequencing rules; each
    // note occupies DIV cycles and note_clk appears 2 cycles after the fetch.
    task automatic play(input logic [9:0] s, input logic [9:0] e, input logic l,
                        input int max_notes, input bit poke_start);
        logic [9:0] q[$];
        logic [9:0] a;
        a = s;
        for (int k = 0; k < max_notes; k++) begin
            q.push_back(a);
            if (a == e) begin
                if (!l) break;
                a = s;
            end else begin
                a = a + 10'd1;
            end
        end
        pulse_start(s, e, l);
        foreach (q[k]) begin
            check("fetch_rd", mem_rd, 1'b1);
            check("fetch_addr", mem_addr, q[k]);
            check("fetch_busy", busy, 1'b1);
            @(negedge clk);
            check("latch_rd", mem_rd, 1'b0);
            check("latch_nclk", note_clk, 1'b0);
            @(negedge clk);
            check("note_clk", note_clk, 1'b1);
            check("note_tones", tones, muted(pat(q[k]), mute));
            check("note_done", done, 1'b0);
            if (poke_start && k == 1) begin
                start = 1'b1;
                start_addr = ~s;
                end_addr = ~e;
            end
            for (int h = 0; h < DIV - 3; h++) begin
                @(negedge clk);
                start = 1'b0;
                check("hold_nclk", note_clk, 1'b0);
                check("hold_done", done, 1'b0);
                check("hold_busy", busy, 1'b1);
            end
            @(negedge clk);
        end
        if (!l) begin
            check("end_done", done, 1'b1);
            check("end_busy", busy, 1'b0);
            check("end_tones", tones, 16'h0);
            check("end_rd", mem_rd, 1'b0);
            @(negedge clk);
            check("end_done_1cyc", done, 1'b0);
            check("end_idle_rd", mem_rd, 1'b0);
        end
    endtask

    // Stop pulse in the first HOLD cycle of the current note
    task automatic stop_mid_hold();
        @(negedge clk);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", busy, 1'b0);
        check("stop_tones", tones, 16'h0);
        check("stop_done", done, 1'b0);
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            check("stopped_rd", mem_rd, 1'b0);
            check("stopped_done", done, 1'b0);
            check("stopped_nclk", note_clk, 1'b0);
        end
    endtask

    initial begin
        logic [9:0] s, e;
        int len;

        // Reset state
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rd", mem_rd, 1'b0);
        check("rst_addr", mem_addr, 10'd0);
        check("rst_tones", tones, 16'h0);
        check("rst_nclk", note_clk, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic four-note playback, then wrap through the top of memory,
        // then a single note
        play(10'd0, 10'd3, 1'b0, 2000, 1'b0);
        play(10'd1022, 10'd1, 1'b0, 2000, 1'b0);
        play(10'd7, 10'd7, 1'b0, 2000, 1'b0);

        // Single-note loop with a start attempt mid-playback, then stop
        play(10'd5, 10'd5, 1'b1, 5, 1'b1);
        stop_mid_hold();

        // Random non-looped ranges
        for (int r = 0; r < 4; r++) begin
            s = 10'($urandom_range(1023, 0));
            len = $urandom_range(5, 1);
            e = s + 10'(len - 1);
            play(s, e, 1'b0, 2000, (r == 0));
        end

        // Random looped range, run past one wrap, then stop
`ifdef CHANNEL_MUTE_EN
        mute = 4'b0010;
`endif
        s = 10'($urandom_range(1023, 0));
        len = $urandom_range(4, 2);
        e = s + 10'(len - 1);
        play(s, e, 1'b1, len + 3, 1'b0);
        stop_mid_hold();
        mute = 4'b0000;

        // start and stop together from IDLE
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        start_addr = 10'd9;
        end_addr = 10'd12;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("ss_busy", busy, 1'b0);
            check("ss_rd", mem_rd, 1'b0);
            @(negedge clk);
        end

        // Reset in the LATCH cycle clears outputs without a clock edge
        pulse_start(10'd300, 10'd302, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_addr", mem_addr, 10'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_tones", tones, 16'h0);
        check("arst_rd", mem_rd, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            check("arst_idle_done", done, 1'b0);
            check("arst_idle_nclk", note_clk, 1'b0);
            check("arst_idle_busy", busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
